// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with clear, load, enable, wrap/saturate
// mode, combinational terminal count for cascading and sticky load-error flag.
module modn_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             tc,
  output logic             wrap,
  output logic             lderr
);

  // Compares are done one bit wider so MODULUS = 2^WIDTH does not overflow.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_W = MOD_W - (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             lderr_q, lderr_d;
  logic             at_max, at_zero;

  assign at_max  = ({1'b0, q_q} == MAX_W);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d     = q_q;
    wrap_d  = 1'b0;
    lderr_d = lderr_q;
    if (clr) begin
      q_d     = '0;
      lderr_d = 1'b0;
    end else if (load) begin
      if ({1'b0, din} < MOD_W) begin
        q_d = din;
      end else begin
        q_d     = MAX_W[WIDTH-1:0];
        lderr_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          wrap_d = 1'b1;
          q_d    = SATURATE ? q_q : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          wrap_d = 1'b1;
          q_d    = SATURATE ? q_q : MAX_W[WIDTH-1:0];
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      wrap_q  <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      lderr_q <= lderr_d;
    end
  end

  assign q     = q_q;
  assign nq    = ~q_q;
  assign wrap  = wrap_q;
  assign lderr = lderr_q;
  assign tc    = en & ((up & at_max) | (~up & at_zero));

endmodule
